// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared types and constants for the ALU multi-cycle mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Default operand / result width.
  localparam int XLEN_DEFAULT = 32;

  // Operation select carried on the op port.
  typedef enum logic [1:0] {
    MUL  = 2'b00,  // low word of signed product
    MULH = 2'b01,  // high word of signed x signed product
    DIV  = 2'b10,  // signed quotient
    REM  = 2'b11   // signed remainder
  } muldiv_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Purpose  : One combinational iteration of the shift-add multiplier or the
//            restoring divider. The 2*XLEN accumulator is {hi, lo}:
//              multiply: hi = partial product, lo = remaining multiplier bits
//              divide  : hi = partial remainder, lo = dividend/quotient bits
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_step
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_out,
  output logic              q_bit
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted_rem;
  logic [XLEN:0] diff;

  // Compute both datapaths and select by operation class.
  always_comb begin
    sum         = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);
    shifted_rem = acc_in[2*XLEN-1:XLEN-1];
    diff        = shifted_rem - {1'b0, operand};
    q_bit       = 1'b0;
    acc_out     = '0;
    if (is_div) begin
      // Borrow clear means the divisor fits: keep the difference.
      q_bit   = ~diff[XLEN];
      acc_out = {(q_bit ? diff[XLEN-1:0] : shifted_rem[XLEN-1:0]),
                 acc_in[XLEN-2:0], q_bit};
    end else begin
      // The carry out of the add shifts into the top of the product.
      acc_out = {sum, acc_in[XLEN-1:1]};
    end
  end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_seq
// Purpose  : Multi-cycle signed MUL/MULH/DIV/REM sequencer with valid/ready
//            request and response handshakes. Operates on magnitudes for
//            XLEN steps, then applies the sign fix when entering DONE.
// Options  : ALU_MULDIV_EARLY_OUT_EN - finish trivial cases on the accept edge
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_DONE = DONE;
  localparam int         CW      = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

  logic [1:0]        state;
  logic [1:0]        op_q;
  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   operand;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     count;

  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] step_acc;
  logic              step_q;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fixed;
  logic              early_hit;
  logic [XLEN-1:0]   early_val;

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);

  assign mag_a = rs1_data[XLEN-1] ? -rs1_data : rs1_data;
  assign mag_b = rs2_data[XLEN-1] ? -rs2_data : rs2_data;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (op_q[1]),
    .acc_in  (acc),
    .operand (operand),
    .acc_out (step_acc),
    .q_bit   (step_q)
  );

  // Sign fix applied to the result of the final step.
  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? -step_acc : step_acc;
    quo      = {step_acc[XLEN-1:1], step_q};
    rem      = step_acc[2*XLEN-1:XLEN];
    case (muldiv_op_e'(op_q))
      MUL:     fixed = prod_fix[XLEN-1:0];
      MULH:    fixed = prod_fix[2*XLEN-1:XLEN];
      DIV:     fixed = (operand == '0) ? '1 : ((neg_a ^ neg_b) ? -quo : quo);
      default: fixed = neg_a ? -rem : rem;
    endcase
  end

`ifdef ALU_MULDIV_EARLY_OUT_EN
  // Detect operations whose result is known at accept time.
  always_comb begin
    early_hit = 1'b0;
    early_val = '0;
    if (op[1]) begin
      if (rs2_data == '0) begin
        early_hit = 1'b1;
        early_val = op[0] ? rs1_data : '1;
      end else if (rs1_data == {1'b1, {(XLEN-1){1'b0}}} && rs2_data == '1) begin
        early_hit = 1'b1;
        early_val = op[0] ? '0 : rs1_data;
      end
    end else if (rs1_data == '0 || rs2_data == '0) begin
      early_hit = 1'b1;
      early_val = '0;
    end
  end
`else
  assign early_hit = 1'b0;
  assign early_val = '0;
`endif

  // Sequencer state, operand capture, iteration and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      operand <= '0;
      acc     <= '0;
      count   <= '0;
      result  <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q    <= op;
            neg_a   <= rs1_data[XLEN-1];
            neg_b   <= rs2_data[XLEN-1];
            count   <= '0;
            // Divide iterates on the dividend; multiply on the multiplier.
            operand <= op[1] ? mag_b : mag_a;
            acc     <= {{XLEN{1'b0}}, (op[1] ? mag_a : mag_b)};
            if (early_hit) begin
              state  <= ST_DONE;
              result <= early_val;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          acc   <= step_acc;
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            state  <= ST_DONE;
            result <= fixed;
          end
        end
        ST_DONE: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : alu_muldiv_seq
`default_nettype wire
